// File: rtl/note_matcher_array_if.sv
// Per-lane note-time fetch handshake between the chart/metadata fetcher (master)
// and the note matcher (slave). Lane i's note time sits at [TIME_W*i +: TIME_W].
interface note_matcher_array_if #(
  parameter int N_LANES = 37,
  parameter int TIME_W  = 18
);
  logic [N_LANES*TIME_W-1:0] metadata_link;
  logic [N_LANES-1:0]        metadata_valid;
  logic [N_LANES-1:0]        metadata_request;

  modport master (
    output metadata_link,
    output metadata_valid,
    input  metadata_request
  );

  modport slave (
    input  metadata_link,
    input  metadata_valid,
    output metadata_request
  );
endinterface

// File: rtl/note_matcher_array.sv
// Per-lane rhythm-game note matcher: fetches each lane's next note time, judges key
// presses against song_time and emits registered hit/miss/stray pulses.
module note_matcher_array #(
  parameter int N_LANES = 37,
  parameter int TIME_W  = 18,
  parameter int WINDOW  = 6
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [TIME_W-1:0]             song_time,
  input  logic [N_LANES-1:0]            NDATA,
  note_matcher_array_if.slave           meta,
  output logic [N_LANES-1:0]            match_trigger,
  output logic [N_LANES*(TIME_W+1)-1:0] match_delta,
  output logic [N_LANES-1:0]            miss_trigger,
  output logic [N_LANES-1:0]            stray_trigger,
  output logic [N_LANES-1:0]            lane_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ARMED,
    S_DONE
  } state_t;

  localparam logic [TIME_W:0]   WIN      = (TIME_W+1)'(WINDOW);
  localparam logic [TIME_W-1:0] SENTINEL = {TIME_W{1'b1}};

  logic [N_LANES-1:0] note_prev_q;
  logic [N_LANES-1:0] key_edge;

  // Resetting to all ones keeps a key held through reset from looking like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) note_prev_q <= '1;
    else          note_prev_q <= NDATA;
  end

  assign key_edge = NDATA & ~note_prev_q;

  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      state_t            state_q, state_d;
      logic [TIME_W-1:0] note_time_q, note_time_d;
      logic [TIME_W:0]   delta_q, delta_d;
      logic              hit_q, hit_d;
      logic              miss_q, miss_d;
      logic              stray_q, stray_d;
      logic [TIME_W-1:0] slice;
      logic [TIME_W:0]   delta;
      logic              late, early;

      assign slice = meta.metadata_link[TIME_W*gi +: TIME_W];
      assign delta = {1'b0, song_time} - {1'b0, note_time_q};
      assign late  = $signed(delta) > $signed(WIN);
      assign early = $signed(delta) < -$signed(WIN);

      always_comb begin
        state_d     = state_q;
        note_time_d = note_time_q;
        delta_d     = delta_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        stray_d     = 1'b0;
        case (state_q)
          S_IDLE: begin
            stray_d = key_edge[gi];
            state_d = S_REQ;
          end
          S_REQ: begin
            stray_d = key_edge[gi];
            state_d = S_WAIT;
          end
          S_WAIT: begin
            stray_d = key_edge[gi];
            if (meta.metadata_valid[gi]) begin
              note_time_d = slice;
              state_d     = (slice == SENTINEL) ? S_DONE : S_ARMED;
            end
          end
          S_ARMED: begin
            // A passed note is judged first, so a late press can only ever be stray.
            if (late) begin
              miss_d  = 1'b1;
              stray_d = key_edge[gi];
              state_d = S_REQ;
            end else if (key_edge[gi]) begin
              if (early) begin
                stray_d = 1'b1;
              end else begin
                hit_d   = 1'b1;
                delta_d = delta;
                state_d = S_REQ;
              end
            end
          end
          S_DONE: begin
            stray_d = key_edge[gi];
          end
          default: state_d = S_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q     <= S_IDLE;
          note_time_q <= '0;
          delta_q     <= '0;
          hit_q       <= 1'b0;
          miss_q      <= 1'b0;
          stray_q     <= 1'b0;
        end else begin
          state_q     <= state_d;
          note_time_q <= note_time_d;
          delta_q     <= delta_d;
          hit_q       <= hit_d;
          miss_q      <= miss_d;
          stray_q     <= stray_d;
        end
      end

      assign meta.metadata_request[gi]               = (state_q == S_REQ);
      assign lane_done[gi]                           = (state_q == S_DONE);
      assign match_trigger[gi]                       = hit_q;
      assign miss_trigger[gi]                        = miss_q;
      assign stray_trigger[gi]                       = stray_q;
      assign match_delta[(TIME_W+1)*gi +: TIME_W+1]  = delta_q;
    end
  endgenerate

endmodule
